// File: rtl/apuf_eval.sv
// Arbiter-PUF evaluation: challenge-steered swap chain, arbiter flop,
// 2-FF synchroniser and a majority-voting evaluation controller.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start, chal    request strobe and challenge (captured in IDLE)
//   arb_ext        external raw arbiter bit (USE_EXT_ARB=1)
//   busy           high outside IDLE
//   resp_valid     one-cycle result pulse
//   resp           majority response
//   ones           count of evaluations that returned 1
//   stable         all evaluations agreed
module apuf_eval #(
  parameter int STAGES      = 64,
  parameter int EVALS       = 7,
  parameter int SETTLE      = 8,
  parameter int USE_EXT_ARB = 0,
  localparam int OW         = $clog2(EVALS + 1),
  localparam int CW         = $clog2(SETTLE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [STAGES-1:0] chal,
  input  logic              arb_ext,
  output logic              busy,
  output logic              resp_valid,
  output logic              resp,
  output logic [OW-1:0]     ones,
  output logic              stable
);

  typedef enum logic [2:0] {
    IDLE,
    DISCHARGE,
    LAUNCH,
    SAMPLE,
    DONE
  } state_t;

  state_t            state_q;
  logic [STAGES-1:0] chal_q;
  logic              launch_q;
  logic [CW-1:0]     cnt_q;
  logic [7:0]        ecnt_q;
  logic [OW-1:0]     acc_q;
  logic              busy_q;
  logic              resp_valid_q;
  logic              resp_q;
  logic [OW-1:0]     ones_q;
  logic              stable_q;
  logic [1:0]        sync_q;
  logic              arb_q;

  // Race paths: index 0 is the shared launch point.
  (* keep = "true", dont_touch = "true" *)
  logic [STAGES:0]   top_w;
  (* keep = "true", dont_touch = "true" *)
  logic [STAGES:0]   bot_w;

  assign top_w[0] = launch_q;
  assign bot_w[0] = launch_q;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    // One dual-output LUT per stage: straight when 0, crossed when 1.
    assign top_w[i+1] = chal_q[i] ? bot_w[i] : top_w[i];
    assign bot_w[i+1] = chal_q[i] ? top_w[i] : bot_w[i];
  end

  // Top arriving before the bottom edge captures 1.
  always_ff @(posedge bot_w[STAGES] or negedge launch_q) begin
    if (!launch_q) arb_q <= 1'b0;
    else           arb_q <= top_w[STAGES];
  end

  logic raw;
  assign raw = (USE_EXT_ARB != 0) ? arb_ext : arb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], raw};
  end

  logic          cnt_last;
  logic [OW-1:0] acc_nx;
  logic [7:0]    ecnt_nx;

  assign cnt_last = (cnt_q == CW'(SETTLE - 1));
  assign acc_nx   = acc_q + OW'(sync_q[1]);
  assign ecnt_nx  = ecnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      chal_q       <= '0;
      launch_q     <= 1'b0;
      cnt_q        <= '0;
      ecnt_q       <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= 1'b0;
      ones_q       <= '0;
      stable_q     <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            chal_q   <= chal;
            acc_q    <= '0;
            ecnt_q   <= '0;
            cnt_q    <= '0;
            launch_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= DISCHARGE;
          end
        end
        DISCHARGE: begin
          if (cnt_last) begin
            cnt_q    <= '0;
            launch_q <= 1'b1;
            state_q  <= LAUNCH;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LAUNCH: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SAMPLE: begin
          if (cnt_q == '0) begin
            cnt_q <= CW'(1);
          end else begin
            cnt_q    <= '0;
            acc_q    <= acc_nx;
            ecnt_q   <= ecnt_nx;
            launch_q <= 1'b0;
            if (ecnt_nx == 8'(EVALS)) begin
              // Results are visible during DONE, alongside the pulse.
              ones_q       <= acc_nx;
              resp_q       <= (acc_nx > OW'(EVALS / 2));
              stable_q     <= (acc_nx == '0) ||
                              (acc_nx == OW'(EVALS));
              resp_valid_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              state_q <= DISCHARGE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp       = resp_q;
  assign ones       = ones_q;
  assign stable     = stable_q;

endmodule

// File: tb/tb_apuf_eval.sv
// Bench for apuf_eval with the external arbiter bit: vector table of
// per-evaluation arbiter sequences plus start-spam and mid-run reset.
module tb_apuf_eval;

  localparam int EV = 18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] chal;
  logic        arb_ext;
  logic        busy;
  logic        resp_valid;
  logic        resp;
  logic [2:0]  ones;
  logic        stable;

  int total = 0;
  int bad   = 0;

  apuf_eval #(
    .STAGES(64),
    .EVALS(7),
    .SETTLE(8),
    .USE_EXT_ARB(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .chal(chal),
    .arb_ext(arb_ext),
    .busy(busy),
    .resp_valid(resp_valid),
    .resp(resp),
    .ones(ones),
    .stable(stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    string      nm;
    logic [6:0] bits;
    bit         spam;
    int         r;
    int         o;
    int         s;
  } vec_t;

  vec_t vt[6];

  task automatic run(input string nm, input logic [6:0] bits,
                     input bit spam, input int rst_at,
                     output int lat, output int pulses);
    logic [63:0] cap;
    cap    = chal;
    start  = 1'b1;
    lat    = -1;
    pulses = 0;
    for (int i = 1; i <= 140; i++) begin
      @(negedge clk);
      if (i == 1 && rst_at == 0)
        chk({nm, "_chalq"}, dut.chal_q == cap, 1);
      if (!spam && i == 1) start = 1'b0;
      if (spam && i == 126) start = 1'b0;
      if (spam && i < 126) chal = {$urandom, $urandom};
      if ((i - 1) % EV == 0 && (i - 1) / EV < 7)
        arb_ext = bits[(i-1)/EV];
      if (!spam && rst_at == 0) begin
        if (i == 1 || i == 8)
          chk({nm, "_lnch_lo"}, dut.launch_q, 0);
        if (i == 9 || i == 18)
          chk({nm, "_lnch_hi"}, dut.launch_q, 1);
        if (i == 19)
          chk({nm, "_lnch_lo2"}, dut.launch_q, 0);
        if (i == 127) chk({nm, "_busy_done"}, busy, 1);
        if (i == 128) chk({nm, "_busy_after"}, busy, 0);
      end
      if (rst_at > 0 && i == rst_at) begin
        chk({nm, "_pre_launch"}, dut.launch_q, 1);
        chk({nm, "_pre_busy"}, busy, 1);
        rst_n = 1'b0;
        #1;
        chk({nm, "_rst_launch"}, dut.launch_q, 0);
        chk({nm, "_rst_busy"}, busy, 0);
      end
      if (resp_valid) begin
        pulses++;
        if (lat < 0) lat = i;
      end
    end
    if (rst_at == 0)
      chk({nm, "_chalq_end"}, dut.chal_q == cap, 1);
    if (rst_at > 0) rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int p;

    vt[0] = '{"all1",  7'b1111111, 1'b0, 1, 7, 1};
    vt[1] = '{"mix4",  7'b1001101, 1'b0, 1, 4, 0};
    vt[2] = '{"mix2",  7'b1001000, 1'b0, 0, 2, 0};
    vt[3] = '{"all0",  7'b0000000, 1'b0, 0, 0, 1};
    vt[4] = '{"spam6", 7'b1111110, 1'b1, 1, 6, 0};
    vt[5] = '{"one1",  7'b0000010, 1'b0, 0, 1, 0};

    rst_n   = 1'b0;
    start   = 1'b0;
    chal    = '0;
    arb_ext = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_resp", resp, 0);
    chk("rst_ones", ones, 0);
    chk("rst_stable", stable, 0);
    chk("rst_launch", dut.launch_q, 0);
    chk("rst_state", int'(dut.state_q), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      chal = {$urandom, $urandom};
      run(vt[v].nm, vt[v].bits, vt[v].spam, 0, lat, p);
      chk({vt[v].nm, "_lat"}, lat, 127);
      chk({vt[v].nm, "_pulses"}, p, 1);
      chk({vt[v].nm, "_resp"}, resp, vt[v].r);
      chk({vt[v].nm, "_ones"}, ones, vt[v].o);
      chk({vt[v].nm, "_stable"}, stable, vt[v].s);
      chk({vt[v].nm, "_idle"}, busy, 0);
    end

    // Reset during LAUNCH of the third evaluation (cycles 45..52).
    chal = {$urandom, $urandom};
    run("midrst", 7'b1111111, 1'b0, 48, lat, p);
    chk("midrst_pulses", p, 0);
    chk("midrst_ones", ones, 0);
    chk("midrst_state", int'(dut.state_q), 0);

    chal = {$urandom, $urandom};
    run("after", 7'b1001101, 1'b0, 0, lat, p);
    chk("after_lat", lat, 127);
    chk("after_pulses", p, 1);
    chk("after_resp", resp, 1);
    chk("after_ones", ones, 4);
    chk("after_stable", stable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apuf_eval.md
# apuf_eval

Parametrised arbiter-PUF evaluation block: a STAGES-long chain of challenge-controlled swap stages ending in an arbiter flop, plus an evaluation controller. The controller launches the chain EVALS times per request, synchronises each arbiter decision into `clk` and returns the majority-voted response with a ones count and a stability flag. It sits between the challenge source (host/UART bridge) and the XOR-combining / response-collection logic, and replaces hand-instantiated single switch stages.

## Interface
- `STAGES`, 64: number of swap stages; challenge width (≥1).
- `EVALS`, 7: evaluations per request; odd, 1..255.
- `SETTLE`, 8: cycles `launch` is held in each of the low and high phases (≥2).
- `USE_EXT_ARB`, 0: 1 = take the raw arbiter bit from `arb_ext` (simulation/bench); 0 = internal arbiter.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request strobe; honoured only in IDLE.
- `chal`  in  STAGES  challenge; bit i controls stage i; captured on the accepted `start` edge.
- `arb_ext`  in  1  external raw arbiter bit (used only when USE_EXT_ARB=1).
- `busy`  out  1  high in every state except IDLE.
- `resp_valid`  out  1  one-cycle pulse when results are updated.
- `resp`  out  1  majority response.
- `ones`  out  $clog2(EVALS+1)  number of evaluations that returned 1.
- `stable`  out  1  1 when all EVALS evaluations agreed.

## Operation
- Chain: both stage-0 inputs are driven by `launch`. Stage i, with `chal_q[i]=0`, passes straight (top→top, bottom→bottom); with `chal_q[i]=1`, it crosses (top→bottom, bottom→top). Each stage is one dual-output LUT marked DONT_TOUCH, and the chain must never be optimised or merged.
- Arbiter: a flop with D = final top and clock = final bottom, asynchronously cleared while `launch=0`. Output 1 means top arrived first.
- Raw bit: internal arbiter output, or `arb_ext` if USE_EXT_ARB=1. It feeds a 2-FF synchroniser clocked by `clk`, reset to 0.
- FSM states are IDLE, DISCHARGE, LAUNCH, SAMPLE and DONE.
  - IDLE: on `start=1`, capture `chal` into `chal_q`, clear the ones accumulator and eval counter, then go to DISCHARGE.
  - DISCHARGE: `launch=0` for SETTLE cycles, then LAUNCH.
  - LAUNCH: `launch=1` for SETTLE cycles, then SAMPLE.
  - SAMPLE: `launch` stays 1 for 2 cycles. On the 2nd cycle, add the synchroniser output to the accumulator and increment the eval counter. If the count has reached EVALS, go to DONE; otherwise go to DISCHARGE.
  - DONE: one cycle. Register `ones` = accumulator, `resp` = (accumulator > EVALS/2), and `stable` = (accumulator==0 or accumulator==EVALS). Pulse `resp_valid`, then return to IDLE.
- `start` outside IDLE is ignored and not queued. `chal` changes after capture have no effect.
- `resp`, `ones` and `stable` hold their values until the next DONE.
- Accumulator width is $clog2(EVALS+1) and cannot overflow. The eval counter is 8 bits.
- Reset (any time, including mid-evaluation) takes effect asynchronously:
  - FSM goes to IDLE; `launch`, `busy`, `resp_valid`, `resp`, `ones`, `stable`, the accumulator, the counter, `chal_q` and the synchroniser all go to 0.
  - The partial evaluation is discarded.

## Timing
- Reset values of all outputs are 0.
- Start accepted at edge k, so DISCHARGE begins at k+1.
- Each evaluation takes 2*SETTLE+2 cycles.
- `resp_valid` is high during cycle k+1+EVALS*(2*SETTLE+2). With defaults that is k+127.
- `busy` is high from k+1 through the DONE cycle inclusive, and low the cycle after.
- Earliest next accepted `start` is the cycle after DONE.
- The synchroniser gives 2 cycles of latency. The raw bit must be stable from the LAUNCH rising edge until the end of SAMPLE, and the bench drives `arb_ext` accordingly.

## Test plan
- Reset: hold `rst_n=0`, then release → all outputs 0, `launch=0`, FSM in IDLE; a `start` in the first cycle after release is accepted.
- USE_EXT_ARB=1, defaults, `arb_ext=1` throughout → `resp_valid` at k+127, `resp=1`, `ones=7`, `stable=1`; `launch` low 8 cycles, then high 10 cycles per evaluation, 7 times.
- Per-evaluation `arb_ext` sequence 1,0,1,1,0,0,1 → `resp=1`, `ones=4`, `stable=0`; then sequence 0,0,0,1,0,0,1 → `resp=0`, `ones=2`, `stable=0`.
- Pulse `start` every cycle while busy and change `chal` mid-run → exactly one `resp_valid` per accepted start; captured `chal_q` unchanged.
- Assert `rst_n=0` mid-LAUNCH of the 3rd evaluation → `launch` and `busy` drop without waiting for a clock edge, no `resp_valid`; a following start completes a full 127-cycle run with fresh counts.
- USE_EXT_ARB=0, STAGES=4, unit-delay stage model: `chal=4'b0000` with the bottom path delayed → `resp=1`; `chal=4'b0001` (odd crossings swap the paths) → `resp=0`.
